// File: rtl/accelerator_vector_integration.sv
// accelerator_vector_integration: accumulates LENGTH*DATA_IN over a vector of SIZE samples, streaming each running sum
module accelerator_vector_integration #(
  parameter int DATA_SIZE = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_IN_ENABLE,
  output logic                 DATA_ENABLE,
  output logic                 DATA_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_IN,
  input  logic [DATA_SIZE-1:0] LENGTH_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT
);
  typedef enum logic [1:0] {STARTER_STATE, INPUT_STATE, ENDER_STATE} state_t;
  state_t state, next_state;
  logic [DATA_SIZE-1:0] acc, idx, size, length, sum;
  logic take;
  assign take = state == INPUT_STATE && DATA_IN_ENABLE;
  assign sum = acc + length * DATA_IN;
  // state register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= STARTER_STATE;
    else state <= next_state;
  // next state and state-decoded handshakes
  always_comb begin
    DATA_ENABLE = state == INPUT_STATE;
    READY = state == ENDER_STATE;
    next_state = state == STARTER_STATE ? (START ? (SIZE_IN == '0 ? ENDER_STATE : INPUT_STATE) : STARTER_STATE) :
                 state == INPUT_STATE ? (take && idx == size - 1'b1 ? ENDER_STATE : INPUT_STATE) :
                 STARTER_STATE;
  end
  // run parameters, accumulator and registered result stream
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      acc <= '0;
      idx <= '0;
      size <= '0;
      length <= '0;
      DATA_OUT <= '0;
      DATA_OUT_ENABLE <= 1'b0;
    end else begin
      DATA_OUT_ENABLE <= take;
      if (state == STARTER_STATE && START) begin
        size <= SIZE_IN;
        length <= LENGTH_IN;
        acc <= '0;
        idx <= '0;
      end
      if (take) begin
        acc <= sum;
        idx <= idx + 1'b1;
        DATA_OUT <= sum;
      end
    end
endmodule
